// File: rtl/bp_defs.sv
// Shared definitions for the branch target predictor: counter encodings,
// FSM states and table-entry field widths.
package bp_defs;

   localparam logic [1:0] CTR_SNT  = 2'b00;
   localparam logic [1:0] CTR_WNT  = 2'b01;
   localparam logic [1:0] CTR_WT   = 2'b10;
   localparam logic [1:0] CTR_ST   = 2'b11;
   // Snapshot reported on a miss so that a later resolution sees "weak not-taken".
   localparam logic [1:0] CTR_MISS = CTR_WNT;

   localparam int CTR_W = 2;
   localparam int TGT_W = 32;

   typedef enum logic {
      BP_INIT = 1'b0,
      BP_RUN  = 1'b1
   } bp_state_e;

endpackage

// File: rtl/bp_sat_counter.sv
// Two-bit saturating direction counter: next value from {ctr, taken}.
module bp_sat_counter
   import bp_defs::*;
(
   input  logic [CTR_W-1:0] ctr_i,
   input  logic             taken_i,
   output logic [CTR_W-1:0] ctr_o
);

   // Step toward the resolved direction, holding at either end.
   always_comb begin
      ctr_o = ctr_i;
      if (taken_i) begin
         if (ctr_i != CTR_ST) ctr_o = ctr_i + 2'd1;
      end else begin
         if (ctr_i != CTR_SNT) ctr_o = ctr_i - 2'd1;
      end
   end

endmodule

// File: rtl/branch_target_predictor.sv
// Direct-mapped BTB with 2-bit direction counters. Registered prediction to IF,
// training from MEM-stage resolutions. Table storage is not reset; an init
// walker clears the valid bits after every reset.
// Optional build macro BP_STATS_EN adds lookup/hit/mispredict counters.
//
// state   | meaning
// BP_INIT | walking the table clearing valid bits; lookups miss, updates dropped
// BP_RUN  | normal lookup and training
module branch_target_predictor
   import bp_defs::*;
#(
   parameter int IDX_BITS = 6,
   parameter int TAG_BITS = 8
) (
   input  logic             CLK,
   input  logic             RESET,
   input  logic [31:0]      Fetch_PC_IN,
   input  logic             Fetch_Valid_IN,
   input  logic             Flush_IN,
   input  logic             Update_Valid_IN,
   input  logic [31:0]      Update_PC_IN,
   input  logic             Update_Taken_IN,
   input  logic [31:0]      Update_Target_IN,
   input  logic [CTR_W-1:0] Update_Counter_IN,
   output logic             Predict_Taken_OUT,
   output logic [31:0]      Predict_Target_OUT,
   output logic [CTR_W-1:0] Predict_Counter_OUT,
   output logic             Ready_OUT
`ifdef BP_STATS_EN
   ,
   output logic [31:0]      Stat_Lookups_OUT,
   output logic [31:0]      Stat_Hits_OUT,
   output logic [31:0]      Stat_Mispredicts_OUT
`endif
);

   localparam int ENTRIES = 1 << IDX_BITS;
   localparam int TAG_HI  = IDX_BITS + TAG_BITS + 1;

   logic                tbl_valid_q  [ENTRIES];
   logic [TAG_BITS-1:0] tbl_tag_q    [ENTRIES];
   logic [TGT_W-1:0]    tbl_target_q [ENTRIES];
   logic [CTR_W-1:0]    tbl_ctr_q    [ENTRIES];

   bp_state_e           state_q, state_d;
   logic [IDX_BITS-1:0] walk_q, walk_d;

   logic                pred_taken_q, pred_taken_d;
   logic [TGT_W-1:0]    pred_target_q, pred_target_d;
   logic [CTR_W-1:0]    pred_ctr_q, pred_ctr_d;
   logic                ready_q, ready_d;

   logic [IDX_BITS-1:0] f_idx, u_idx;
   logic [TAG_BITS-1:0] f_tag, u_tag;
   logic                lk_hit, up_hit, run;
   logic [CTR_W-1:0]    ctr_next;

   assign f_idx  = Fetch_PC_IN[IDX_BITS+1:2];
   assign f_tag  = Fetch_PC_IN[TAG_HI:IDX_BITS+2];
   assign u_idx  = Update_PC_IN[IDX_BITS+1:2];
   assign u_tag  = Update_PC_IN[TAG_HI:IDX_BITS+2];
   assign run    = (state_q == BP_RUN);
   assign lk_hit = tbl_valid_q[f_idx] && (tbl_tag_q[f_idx] == f_tag);
   assign up_hit = tbl_valid_q[u_idx] && (tbl_tag_q[u_idx] == u_tag);

   // Bits outside index/tag and the statistics-only snapshot are deliberately ignored.
   logic unused_ok;
   assign unused_ok = ^{Fetch_PC_IN[31:TAG_HI+1], Fetch_PC_IN[1:0],
                        Update_PC_IN[31:TAG_HI+1], Update_PC_IN[1:0], Update_Counter_IN};

   bp_sat_counter u_sat (
      .ctr_i   (tbl_ctr_q[u_idx]),
      .taken_i (Update_Taken_IN),
      .ctr_o   (ctr_next)
   );

   // Next state: walk every index once, then stay in RUN until reset.
   always_comb begin
      state_d = state_q;
      walk_d  = walk_q;
      case (state_q)
         BP_INIT: begin
            walk_d = walk_q + 1'b1;
            if (walk_q == {IDX_BITS{1'b1}}) state_d = BP_RUN;
         end
         default: ;
      endcase
   end

   // Prediction for the next cycle; table reads see pre-update contents.
   always_comb begin
      pred_taken_d  = 1'b0;
      pred_target_d = pred_target_q;
      pred_ctr_d    = pred_ctr_q;
      if (Fetch_Valid_IN) begin
         if (run && lk_hit) begin
            pred_taken_d  = tbl_ctr_q[f_idx][1];
            pred_target_d = tbl_target_q[f_idx];
            pred_ctr_d    = tbl_ctr_q[f_idx];
         end else begin
            pred_target_d = '0;
            pred_ctr_d    = CTR_MISS;
         end
      end
      if (Flush_IN) pred_taken_d = 1'b0;
      ready_d = (state_d == BP_RUN);
   end

   // Control and output registers.
   always_ff @(posedge CLK or negedge RESET) begin
      if (!RESET) begin
         state_q       <= BP_INIT;
         walk_q        <= '0;
         pred_taken_q  <= 1'b0;
         pred_target_q <= '0;
         pred_ctr_q    <= '0;
         ready_q       <= 1'b0;
      end else begin
         state_q       <= state_d;
         walk_q        <= walk_d;
         pred_taken_q  <= pred_taken_d;
         pred_target_q <= pred_target_d;
         pred_ctr_q    <= pred_ctr_d;
         ready_q       <= ready_d;
      end
   end

   // Table storage: cleared by the walker in INIT, trained by resolutions in RUN.
   always_ff @(posedge CLK) begin
      if (!run) begin
         tbl_valid_q[walk_q] <= 1'b0;
      end else if (Update_Valid_IN) begin
         if (up_hit) begin
            tbl_ctr_q[u_idx] <= ctr_next;
            if (Update_Taken_IN) tbl_target_q[u_idx] <= Update_Target_IN;
         end else if (Update_Taken_IN) begin
            tbl_valid_q[u_idx]  <= 1'b1;
            tbl_tag_q[u_idx]    <= u_tag;
            tbl_target_q[u_idx] <= Update_Target_IN;
            tbl_ctr_q[u_idx]    <= CTR_WT;
         end
      end
   end

   assign Predict_Taken_OUT   = pred_taken_q;
   assign Predict_Target_OUT  = pred_target_q;
   assign Predict_Counter_OUT = pred_ctr_q;
   assign Ready_OUT           = ready_q;

`ifdef BP_STATS_EN
   logic [31:0] stat_lk_q, stat_hit_q, stat_mis_q;

   // Free-running wrap-around statistics, RUN activity only.
   always_ff @(posedge CLK or negedge RESET) begin
      if (!RESET) begin
         stat_lk_q  <= '0;
         stat_hit_q <= '0;
         stat_mis_q <= '0;
      end else if (run) begin
         if (Fetch_Valid_IN) stat_lk_q <= stat_lk_q + 32'd1;
         if (Fetch_Valid_IN && lk_hit) stat_hit_q <= stat_hit_q + 32'd1;
         if (Update_Valid_IN && (Update_Counter_IN[1] != Update_Taken_IN))
            stat_mis_q <= stat_mis_q + 32'd1;
      end
   end

   assign Stat_Lookups_OUT     = stat_lk_q;
   assign Stat_Hits_OUT        = stat_hit_q;
   assign Stat_Mispredicts_OUT = stat_mis_q;
`endif

endmodule

// File: tb/tb_branch_target_predictor.sv
// Self-checking bench for branch_target_predictor: directed vectors, a
// behavioural table model compared every cycle, and literal expectations.
module tb_branch_target_predictor;

   logic        CLK = 1'b0;
   logic        RESET = 1'b0;
   logic [31:0] Fetch_PC_IN = '0;
   logic        Fetch_Valid_IN = 1'b0;
   logic        Flush_IN = 1'b0;
   logic        Update_Valid_IN = 1'b0;
   logic [31:0] Update_PC_IN = '0;
   logic        Update_Taken_IN = 1'b0;
   logic [31:0] Update_Target_IN = '0;
   logic [1:0]  Update_Counter_IN = '0;
   logic        Predict_Taken_OUT;
   logic [31:0] Predict_Target_OUT;
   logic [1:0]  Predict_Counter_OUT;
   logic        Ready_OUT;
`ifdef BP_STATS_EN
   logic [31:0] Stat_Lookups_OUT, Stat_Hits_OUT, Stat_Mispredicts_OUT;
`endif

   branch_target_predictor dut (
      .CLK                 (CLK),
      .RESET               (RESET),
      .Fetch_PC_IN         (Fetch_PC_IN),
      .Fetch_Valid_IN      (Fetch_Valid_IN),
      .Flush_IN            (Flush_IN),
      .Update_Valid_IN     (Update_Valid_IN),
      .Update_PC_IN        (Update_PC_IN),
      .Update_Taken_IN     (Update_Taken_IN),
      .Update_Target_IN    (Update_Target_IN),
      .Update_Counter_IN   (Update_Counter_IN),
      .Predict_Taken_OUT   (Predict_Taken_OUT),
      .Predict_Target_OUT  (Predict_Target_OUT),
      .Predict_Counter_OUT (Predict_Counter_OUT),
      .Ready_OUT           (Ready_OUT)
`ifdef BP_STATS_EN
      ,
      .Stat_Lookups_OUT     (Stat_Lookups_OUT),
      .Stat_Hits_OUT        (Stat_Hits_OUT),
      .Stat_Mispredicts_OUT (Stat_Mispredicts_OUT)
`endif
   );

   always #5 CLK = ~CLK;

   int passed = 0;
   int total  = 0;
   bit check_en = 1'b0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) $display("FAIL %s: got %h expected %h", name, act, exp);
      else passed++;
   endtask

   // ---------------- behavioural model ----------------
   bit          m_valid [64];
   logic [7:0]  m_tag   [64];
   logic [31:0] m_tgt   [64];
   int          m_ctr   [64];
   int          init_left = 64;
   logic        exp_taken = 0;
   logic [31:0] exp_target = 0;
   logic [1:0]  exp_ctr = 0;
   logic        exp_ready = 0;
   logic [31:0] exp_lk = 0, exp_hit = 0, exp_mis = 0;

   function automatic int pc_idx(input logic [31:0] pc);
      return int'((pc >> 2) % 64);
   endfunction

   function automatic logic [7:0] pc_tag(input logic [31:0] pc);
      logic [31:0] t;
      t = pc >> 8;
      return t[7:0];
   endfunction

   function automatic bit m_hit(input logic [31:0] pc);
      return m_valid[pc_idx(pc)] && (m_tag[pc_idx(pc)] == pc_tag(pc));
   endfunction

   function automatic int trained(input int c, input bit taken);
      if (taken) return (c + 1 > 3) ? 3 : c + 1;
      return (c - 1 < 0) ? 0 : c - 1;
   endfunction

   always @(posedge CLK or negedge RESET) begin
      if (!RESET) begin
         exp_taken  <= 0;
         exp_target <= 0;
         exp_ctr    <= 0;
         exp_ready  <= 0;
         init_left  <= 64;
         exp_lk <= 0; exp_hit <= 0; exp_mis <= 0;
         for (int i = 0; i < 64; i++) m_valid[i] <= 0;
      end else begin
         if (Fetch_Valid_IN) begin
            if (init_left == 0 && m_hit(Fetch_PC_IN)) begin
               exp_taken  <= (m_ctr[pc_idx(Fetch_PC_IN)] >= 2) && !Flush_IN;
               exp_target <= m_tgt[pc_idx(Fetch_PC_IN)];
               exp_ctr    <= 2'(m_ctr[pc_idx(Fetch_PC_IN)]);
               exp_hit    <= exp_hit + 1;
            end else begin
               exp_taken  <= 0;
               exp_target <= 0;
               exp_ctr    <= 2'b01;
            end
            if (init_left == 0) exp_lk <= exp_lk + 1;
         end else begin
            exp_taken <= 0;
         end
         if (init_left == 0 && Update_Valid_IN) begin
            if (Update_Counter_IN[1] != Update_Taken_IN) exp_mis <= exp_mis + 1;
            if (m_hit(Update_PC_IN)) begin
               m_ctr[pc_idx(Update_PC_IN)] <= trained(m_ctr[pc_idx(Update_PC_IN)], Update_Taken_IN);
               if (Update_Taken_IN) m_tgt[pc_idx(Update_PC_IN)] <= Update_Target_IN;
            end else if (Update_Taken_IN) begin
               m_valid[pc_idx(Update_PC_IN)] <= 1;
               m_tag[pc_idx(Update_PC_IN)]   <= pc_tag(Update_PC_IN);
               m_tgt[pc_idx(Update_PC_IN)]   <= Update_Target_IN;
               m_ctr[pc_idx(Update_PC_IN)]   <= 2;
            end
         end
         if (init_left > 0) begin
            init_left <= init_left - 1;
            if (init_left == 1) exp_ready <= 1;
         end
      end
   end

   // Compare DUT against the model on every falling edge.
   always @(negedge CLK) begin
      if (check_en) begin
         check("cyc_taken",  {31'd0, Predict_Taken_OUT}, {31'd0, exp_taken});
         check("cyc_target", Predict_Target_OUT, exp_target);
         check("cyc_ctr",    {30'd0, Predict_Counter_OUT}, {30'd0, exp_ctr});
         check("cyc_ready",  {31'd0, Ready_OUT}, {31'd0, exp_ready});
`ifdef BP_STATS_EN
         check("cyc_lookups", Stat_Lookups_OUT, exp_lk);
         check("cyc_hits",    Stat_Hits_OUT, exp_hit);
         check("cyc_mispred", Stat_Mispredicts_OUT, exp_mis);
`endif
      end
   end

   // ---------------- stimulus ----------------
   task automatic step(input bit fv, input logic [31:0] fpc, input bit fl,
                       input bit uv, input logic [31:0] upc, input bit ut,
                       input logic [31:0] utgt, input logic [1:0] uctr);
      Fetch_Valid_IN    = fv;
      Fetch_PC_IN       = fpc;
      Flush_IN          = fl;
      Update_Valid_IN   = uv;
      Update_PC_IN      = upc;
      Update_Taken_IN   = ut;
      Update_Target_IN  = utgt;
      Update_Counter_IN = uctr;
      @(negedge CLK);
      Fetch_Valid_IN  = 0;
      Flush_IN        = 0;
      Update_Valid_IN = 0;
   endtask

   task automatic lookup(input logic [31:0] pc);
      step(1, pc, 0, 0, 0, 0, 0, 0);
   endtask

   task automatic update(input logic [31:0] pc, input bit t, input logic [31:0] tgt, input logic [1:0] c);
      step(0, 0, 0, 1, pc, t, tgt, c);
   endtask

   task automatic expect_pred(input string name, input bit t, input logic [31:0] tgt, input logic [1:0] c);
      check({name, "_taken"},  {31'd0, Predict_Taken_OUT}, {31'd0, t});
      check({name, "_target"}, Predict_Target_OUT, tgt);
      check({name, "_ctr"},    {30'd0, Predict_Counter_OUT}, {30'd0, c});
   endtask

   task automatic wait_ready(input string name);
      int cnt;
      cnt = 0;
      while (!Ready_OUT && cnt < 200) begin
         cnt++;
         @(negedge CLK);
      end
      check(name, cnt, 64);
   endtask

   localparam logic [31:0] PC_A = 32'h0040_0020;
   localparam logic [31:0] PC_B = 32'h0040_0120;

   initial begin
      RESET = 0;
      repeat (3) @(negedge CLK);
      check_en = 1;
      check("reset_ready", {31'd0, Ready_OUT}, 32'd0);
      check("reset_ctr",   {30'd0, Predict_Counter_OUT}, 32'd0);
      RESET = 1;
      wait_ready("init_len");

      // 1: cold lookup misses
      lookup(PC_A);
      expect_pred("t1", 0, 32'h0, 2'b01);

      // 2: allocate on taken
      update(PC_A, 1, 32'h0040_0100, 2'b01);
      lookup(PC_A);
      expect_pred("t2", 1, 32'h0040_0100, 2'b10);
`ifdef BP_STATS_EN
      check("t2_lookups", Stat_Lookups_OUT, 32'd2);
      check("t2_hits",    Stat_Hits_OUT, 32'd1);
      check("t2_mispred", Stat_Mispredicts_OUT, 32'd1);
`endif
      // idle cycle: taken drops, target holds
      @(negedge CLK);
      expect_pred("hold", 0, 32'h0040_0100, 2'b10);

      // 3: train down, then up with saturation
      update(PC_A, 0, 32'h0, 2'b10);
      lookup(PC_A);
      expect_pred("t3a", 0, 32'h0040_0100, 2'b01);
      update(PC_A, 0, 32'h0, 2'b01);
      lookup(PC_A);
      expect_pred("t3b", 0, 32'h0040_0100, 2'b00);
      for (int i = 0; i < 4; i++) update(PC_A, 1, 32'h0040_0100, 2'b00);
      lookup(PC_A);
      expect_pred("t3c", 1, 32'h0040_0100, 2'b11);
      update(PC_A, 1, 32'h0040_0100, 2'b11);
      lookup(PC_A);
      expect_pred("t3d", 1, 32'h0040_0100, 2'b11);

      // 4: alias replaces the entry
      update(PC_B, 1, 32'h0040_0200, 2'b01);
      lookup(PC_A);
      expect_pred("t4a", 0, 32'h0, 2'b01);
      lookup(PC_B);
      expect_pred("t4b", 1, 32'h0040_0200, 2'b10);
      // not-taken miss leaves the table alone
      update(PC_A, 0, 32'h0, 2'b00);
      lookup(PC_B);
      expect_pred("t4c", 1, 32'h0040_0200, 2'b10);

      // 5: same-edge lookup/update, then flush
      step(1, PC_B, 0, 1, PC_B, 1, 32'h0040_0300, 2'b10);
      expect_pred("t5a", 1, 32'h0040_0200, 2'b10);
      lookup(PC_B);
      expect_pred("t5b", 1, 32'h0040_0300, 2'b11);
      step(1, PC_B, 1, 0, 0, 0, 0, 0);
      expect_pred("t5c", 0, 32'h0040_0300, 2'b11);

      // 6: async reset mid-run, then mid-init
      #2 RESET = 0;
      #1 expect_pred("t6a", 0, 32'h0, 2'b00);
      check("t6a_ready", {31'd0, Ready_OUT}, 32'd0);
      repeat (2) @(negedge CLK);
      RESET = 1;
      repeat (29) @(negedge CLK);
      lookup(PC_B);
      expect_pred("t6b", 0, 32'h0, 2'b01);
      #2 RESET = 0;
      #1 expect_pred("t6c", 0, 32'h0, 2'b00);
      repeat (2) @(negedge CLK);
      RESET = 1;
      wait_ready("reinit_len");
      lookup(PC_B);
      expect_pred("t6d", 0, 32'h0, 2'b01);
      update(PC_A, 1, 32'h0040_0400, 2'b01);
      lookup(PC_A);
      expect_pred("t6e", 1, 32'h0040_0400, 2'b10);

      repeat (2) @(negedge CLK);
      check_en = 0;
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
